// File: rtl/demux_1xn_gather.sv
// Serial-to-parallel gather: packs LANES consecutive valid words onto LANES output lanes.
// Optional macro DEMUX_PARTIAL_FLUSH_EN: an input gap while filling emits the partial group.
//
//   state | meaning
//   IDLE  | cnt=0, no words staged
//   FILL  | 1..LANES-1 words staged, waiting for the rest of the group
module demux_1xn_gather #(
  parameter int WIDTH = 8,
  parameter int LANES = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     valid_in,
  input  logic [WIDTH-1:0]         data_in,
  output logic [LANES*WIDTH-1:0]   data_out,
  output logic [LANES-1:0]         valid_out
);

  localparam int CW = $clog2(LANES);
  localparam logic [CW-1:0] LAST_LANE = CW'(LANES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CW-1:0]          r_cnt;
  logic [CW-1:0]          w_cnt_nxt;
  logic [WIDTH-1:0]       r_stage     [LANES];
  logic [WIDTH-1:0]       w_stage_nxt [LANES];
  logic [LANES*WIDTH-1:0] r_data_out;
  logic [LANES*WIDTH-1:0] w_data_nxt;
  logic [LANES-1:0]       r_valid_out;
  logic [LANES-1:0]       w_valid_nxt;
  logic                   w_last;

  assign w_last = (r_cnt == LAST_LANE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_data_out  <= '0;
      r_valid_out <= '0;
      for (int k = 0; k < LANES; k++) begin
        r_stage[k] <= '0;
      end
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_data_out  <= w_data_nxt;
      r_valid_out <= w_valid_nxt;
      for (int k = 0; k < LANES; k++) begin
        r_stage[k] <= w_stage_nxt[k];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_data_nxt  = r_data_out;
    w_valid_nxt = '0;
    for (int k = 0; k < LANES; k++) begin
      w_stage_nxt[k] = r_stage[k];
    end

    if (valid_in) begin
      for (int k = 0; k < LANES; k++) begin
        if (r_cnt == CW'(k)) begin
          w_stage_nxt[k] = data_in;
        end
      end
      if (w_last) begin
        // The closing word goes straight to the top lane; staging for it is never read.
        for (int k = 0; k < LANES; k++) begin
          w_data_nxt[k*WIDTH +: WIDTH] = (k == LANES - 1) ? data_in : r_stage[k];
        end
        w_valid_nxt = '1;
        w_cnt_nxt   = '0;
        w_state_nxt = IDLE;
      end else begin
        w_cnt_nxt   = r_cnt + CW'(1);
        w_state_nxt = FILL;
      end
    end
`ifdef DEMUX_PARTIAL_FLUSH_EN
    else if (r_state == FILL) begin
      for (int k = 0; k < LANES; k++) begin
        if (k < int'(r_cnt)) begin
          w_data_nxt[k*WIDTH +: WIDTH] = r_stage[k];
          w_valid_nxt[k]               = 1'b1;
        end else begin
          w_data_nxt[k*WIDTH +: WIDTH] = '0;
        end
      end
      w_cnt_nxt   = '0;
      w_state_nxt = IDLE;
    end
`endif
  end

  assign data_out  = r_data_out;
  assign valid_out = r_valid_out;

endmodule
